// File: rtl/nios_security_pwm_gen.sv
// nios_security_pwm_gen: fixed-period, clamped servo/ESC pulse generator fed by a software duty word
module nios_security_pwm_gen #(
  parameter int unsigned PERIOD    = 1000000,
  parameter int unsigned MIN_PULSE = 50000,
  parameter int unsigned MAX_PULSE = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [31:0] duty_in,
  output logic        pwm_out,
  output logic        period_tick,
  output logic        clamped,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  localparam logic [31:0] LAST = 32'(PERIOD - 1);
  localparam logic [31:0] MIN  = 32'(MIN_PULSE);
  localparam logic [31:0] MAX  = 32'(MAX_PULSE);
  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d, shadow_q, shadow_d, duty_c;
  logic        pwm_q, pwm_d, tick_q, tick_d, clamped_q, clamped_d;
  logic        lo, hi, wrap, idle, load;
  // Next-state: the shadow reloads on leaving IDLE and at each period wrap unless a drain is finishing
  always_comb begin
    lo        = duty_in < MIN;
    hi        = duty_in > MAX;
    duty_c    = lo ? MIN : hi ? MAX : duty_in;
    idle      = state_q == IDLE;
    wrap      = cnt_q == LAST;
    load      = idle ? enable : wrap && (state_q == RUN || enable);
    state_d   = enable ? RUN : (idle || (state_q == DRAIN && wrap)) ? IDLE : DRAIN;
    cnt_d     = (idle || wrap) ? 32'd0 : cnt_q + 32'd1;
    shadow_d  = load ? duty_c : shadow_q;
    clamped_d = load ? (lo | hi) : clamped_q;
    tick_d    = load;
    pwm_d     = !idle && (cnt_q < shadow_q);
  end
  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shadow_q  <= MIN;
      pwm_q     <= 1'b0;
      tick_q    <= 1'b0;
      clamped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      pwm_q     <= pwm_d;
      tick_q    <= tick_d;
      clamped_q <= clamped_d;
    end
  end
  assign pwm_out     = pwm_q;
  assign period_tick = tick_q;
  assign clamped     = clamped_q;
  assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_nios_security_pwm_gen.sv
// tb_nios_security_pwm_gen: randomized and directed checks against a period-timeline reference model
module tb_nios_security_pwm_gen;
  localparam int P = 100, MN = 10, MX = 20;
  logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0;
  logic [31:0] duty_in = 32'd15;
  logic pwm_out, period_tick, clamped, busy;
  int tests = 0, fails = 0;
  int cyc = 0, m_start = 0;
  logic m_busy = 0, m_run = 0, m_pwm = 0, m_tick = 0, m_clamp = 0;
  logic [31:0] m_len = 32'(MN);

  nios_security_pwm_gen #(.PERIOD(P), .MIN_PULSE(MN), .MAX_PULSE(MX)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .duty_in(duty_in),
    .pwm_out(pwm_out), .period_tick(period_tick), .clamped(clamped), .busy(busy));

  always #5 clk = ~clk;

  // Advance one clock; the model tracks when the current period started and how long its pulse is
  task automatic step();
    int pos;
    @(posedge clk);
    cyc++;
    if (!reset_n) begin
      m_busy = 0; m_run = 0; m_len = 32'(MN); m_clamp = 0; m_tick = 0; m_pwm = 0;
    end else begin
      pos = cyc - 1 - m_start;
      m_pwm = m_busy && (pos < int'(m_len));
      m_tick = 0;
      if (!m_busy ? enable : (pos == P - 1 && (m_run || enable))) begin
        m_start = cyc; m_busy = 1; m_tick = 1;
        m_len = duty_in < MN ? 32'(MN) : duty_in > MX ? 32'(MX) : duty_in;
        m_clamp = (duty_in < MN) || (duty_in > MX);
      end else if (m_busy && pos == P - 1) m_busy = 0;
      m_run = enable;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 0; enable = 0; step(); step();
    tests++;
    if ({pwm_out, period_tick, clamped, busy} !== 4'b0) begin
      fails++; $display("FAIL reset: got %b want 0000", {pwm_out, period_tick, clamped, busy});
    end
    reset_n = 1;
  endtask

  task automatic test_nominal();
    int highs = 0, ticks = 0;
    reset_n = 0; step(); reset_n = 1;
    duty_in = 15; enable = 1;
    for (int i = 0; i < 250; i++) begin
      step();
      highs += int'(pwm_out); ticks += int'(period_tick);
      tests++;
      if ({pwm_out, period_tick, clamped, busy} !== {m_pwm, m_tick, m_clamp, m_busy}) begin
        fails++; $display("FAIL nominal cyc %0d: got %b want %b", i, {pwm_out, period_tick, clamped, busy}, {m_pwm, m_tick, m_clamp, m_busy});
      end
    end
    tests++;
    if (highs !== 45 || ticks !== 3) begin
      fails++; $display("FAIL nominal_counts: got highs %0d ticks %0d want 45 3", highs, ticks);
    end
  endtask

  task automatic test_clamp();
    int h0 = 0, h1 = 0, c0 = 0, c1 = 0;
    reset_n = 0; step(); reset_n = 1;
    duty_in = 5; enable = 1;
    for (int i = 0; i < 200; i++) begin
      if (i == 50) duty_in = 32'hFFFF_FFFF;
      step();
      if (i < 100) begin h0 += int'(pwm_out); c0 += int'(clamped); end
      else begin h1 += int'(pwm_out); c1 += int'(clamped); end
      tests++;
      if ({pwm_out, period_tick, clamped, busy} !== {m_pwm, m_tick, m_clamp, m_busy}) begin
        fails++; $display("FAIL clamp cyc %0d: got %b want %b", i, {pwm_out, period_tick, clamped, busy}, {m_pwm, m_tick, m_clamp, m_busy});
      end
    end
    tests++;
    if (h0 !== 10 || h1 !== 20 || c0 !== 100 || c1 !== 100) begin
      fails++; $display("FAIL clamp_counts: got %0d %0d %0d %0d want 10 20 100 100", h0, h1, c0, c1);
    end
  endtask

  task automatic test_mid_update();
    int h0 = 0, h1 = 0;
    reset_n = 0; step(); reset_n = 1;
    duty_in = 12; enable = 1;
    for (int i = 0; i < 200; i++) begin
      if (i == 6) duty_in = 18;
      step();
      if (i < 100) h0 += int'(pwm_out); else h1 += int'(pwm_out);
      tests++;
      if ({pwm_out, period_tick, clamped, busy} !== {m_pwm, m_tick, m_clamp, m_busy}) begin
        fails++; $display("FAIL mid_update cyc %0d: got %b want %b", i, {pwm_out, period_tick, clamped, busy}, {m_pwm, m_tick, m_clamp, m_busy});
      end
    end
    tests++;
    if (h0 !== 12 || h1 !== 18) begin
      fails++; $display("FAIL mid_update_counts: got %0d %0d want 12 18", h0, h1);
    end
  endtask

  task automatic test_drain();
    int highs = 0, ticks = 0;
    reset_n = 0; step(); reset_n = 1;
    duty_in = 15; enable = 1;
    for (int i = 0; i < 200; i++) begin
      if (i == 4) enable = 0;
      step();
      highs += int'(pwm_out); ticks += int'(period_tick);
      tests++;
      if ({pwm_out, period_tick, clamped, busy} !== {m_pwm, m_tick, m_clamp, m_busy}) begin
        fails++; $display("FAIL drain cyc %0d: got %b want %b", i, {pwm_out, period_tick, clamped, busy}, {m_pwm, m_tick, m_clamp, m_busy});
      end
    end
    tests++;
    if (highs !== 15 || ticks !== 1 || busy !== 1'b0) begin
      fails++; $display("FAIL drain_counts: got highs %0d ticks %0d busy %b want 15 1 0", highs, ticks, busy);
    end
  endtask

  task automatic test_reenable();
    int ticks = 0, highs = 0;
    reset_n = 0; step(); reset_n = 1;
    duty_in = 15; enable = 1;
    for (int i = 0; i < 300; i++) begin
      if (i == 51) enable = 0;
      if (i == 71) enable = 1;
      step();
      highs += int'(pwm_out); ticks += int'(period_tick);
      tests++;
      if ({pwm_out, period_tick, clamped, busy} !== {m_pwm, m_tick, m_clamp, m_busy}) begin
        fails++; $display("FAIL reenable cyc %0d: got %b want %b", i, {pwm_out, period_tick, clamped, busy}, {m_pwm, m_tick, m_clamp, m_busy});
      end
    end
    tests++;
    if (ticks !== 3 || highs !== 45) begin
      fails++; $display("FAIL reenable_counts: got ticks %0d highs %0d want 3 45", ticks, highs);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int ticks = 0;
    reset_n = 0; step(); reset_n = 1;
    duty_in = 15; enable = 1;
    for (int i = 0; i < 8; i++) step();
    tests++;
    if (pwm_out !== 1'b1) begin
      fails++; $display("FAIL pre_reset_pulse: got %b want 1", pwm_out);
    end
    reset_n = 0; step(); reset_n = 1;
    tests++;
    if ({pwm_out, period_tick, clamped, busy} !== 4'b0) begin
      fails++; $display("FAIL reset_mid_pulse: got %b want 0000", {pwm_out, period_tick, clamped, busy});
    end
    for (int i = 0; i < 210; i++) begin
      step();
      ticks += int'(period_tick);
      tests++;
      if ({pwm_out, period_tick, clamped, busy} !== {m_pwm, m_tick, m_clamp, m_busy}) begin
        fails++; $display("FAIL restart cyc %0d: got %b want %b", i, {pwm_out, period_tick, clamped, busy}, {m_pwm, m_tick, m_clamp, m_busy});
      end
    end
    tests++;
    if (ticks !== 3) begin
      fails++; $display("FAIL restart_ticks: got %0d want 3", ticks);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(60) == 0) enable = ~enable;
      if ($urandom_range(20) == 0) duty_in = $urandom_range(1) ? $urandom : 32'($urandom_range(30));
      reset_n = $urandom_range(700) != 0;
      step();
      tests++;
      if ({pwm_out, period_tick, clamped, busy} !== {m_pwm, m_tick, m_clamp, m_busy}) begin
        fails++; $display("FAIL random cyc %0d: got %b want %b", i, {pwm_out, period_tick, clamped, busy}, {m_pwm, m_tick, m_clamp, m_busy});
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_clamp();
    test_mid_update();
    test_drain();
    test_reenable();
    test_reset_mid_pulse();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
